// File: rtl/ekf_stage_seq.sv
// Sequencer that launches one EKF stage engine at a time and captures its result bus on completion.
// Optional watchdog on the wait for done is built only when STAGE_TIMEOUT_EN is defined.
module ekf_stage_seq #(
    parameter int                 DW      = 16,
    parameter int                 NSTG    = 3,
    parameter int                 NRES    = 6,
    parameter int                 ROW_LEN = 10,
    parameter logic [NSTG-1:0]    LK_CHK  = NSTG'(3'b100),
    parameter int                 TO_CYC  = 1000
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic [NSTG-1:0]       stage_val,
    output logic [NSTG-1:0]       stage_rdy,
    input  logic [ROW_LEN-1:0]    landmark_num,
    input  logic [ROW_LEN-1:0]    l_k,
    output logic [NSTG-1:0]       init,
    input  logic [NSTG-1:0]       done,
    input  logic [NRES*DW-1:0]    result,
    output logic [NRES*DW-1:0]    res_q,
    output logic                  res_vld,
    output logic [ROW_LEN-1:0]    lm_num_q,
    output logic [ROW_LEN-1:0]    lk_q,
    output logic [NSTG-1:0]       cur_stage,
    output logic                  err_lk,
    output logic                  err_to
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t          state, state_nxt;
    logic [NSTG-1:0] sel_oh;
    logic            lk_bad;
    logic            done_hit;
    logic            to_hit;
    logic            accept;
    logic            reject;
    logic            capture;
    logic            tmo;

    // Two's-complement trick isolates the lowest set request bit.
    assign sel_oh    = stage_val & (~stage_val + NSTG'(1));
    assign lk_bad    = (|(sel_oh & LK_CHK)) && (l_k >= landmark_num);
    assign done_hit  = |(done & cur_stage);
    assign stage_rdy = (state == IDLE && sys_rst) ? {NSTG{1'b1}} : {NSTG{1'b0}};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        capture   = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (|stage_val) begin
                    if (lk_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = LAUNCH;
                    end
                end
            end
            LAUNCH: state_nxt = WAIT;
            WAIT: begin
                if (done_hit) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (to_hit) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            init      <= '0;
            res_q     <= '0;
            res_vld   <= 1'b0;
            lm_num_q  <= '0;
            lk_q      <= '0;
            cur_stage <= '0;
            err_lk    <= 1'b0;
        end else begin
            init    <= accept ? sel_oh : '0;
            err_lk  <= reject;
            res_vld <= capture;
            if (state == IDLE && (|stage_val)) begin
                lm_num_q <= landmark_num;
                lk_q     <= l_k;
            end
            if (accept) begin
                cur_stage <= sel_oh;
            end else if (capture || tmo) begin
                cur_stage <= '0;
            end
            if (capture) begin
                res_q <= result;
            end
        end
    end

`ifdef STAGE_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);
    logic [CW-1:0] to_cnt;

    // Count of completed WAIT cycles; expiry fires on the edge ending the TO_CYC-th one.
    assign to_hit = (to_cnt == CW'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            to_cnt <= '0;
            err_to <= 1'b0;
        end else begin
            err_to <= tmo;
            if (state == LAUNCH) begin
                to_cnt <= '0;
            end else if (state == WAIT) begin
                to_cnt <= to_cnt + CW'(1);
            end
        end
    end
`else
    localparam int to_cyc_unused = TO_CYC;
    assign to_hit = 1'b0;
    assign err_to = 1'b0;
`endif

endmodule

// File: tb/tb_ekf_stage_seq.sv
// Directed and randomized bench for ekf_stage_seq against a request/response reference model.
module tb_ekf_stage_seq;
    localparam int DW = 16, NSTG = 3, NRES = 6, RL = 10, W = NRES * DW;

    logic            clk = 1'b0;
    logic            sys_rst = 1'b0;
    logic [2:0]      stage_val = '0;
    logic [2:0]      done = '0;
    logic [RL-1:0]   landmark_num = '0;
    logic [RL-1:0]   l_k = '0;
    logic [W-1:0]    result = '0;
    logic [2:0]      stage_rdy, init, cur_stage;
    logic [W-1:0]    res_q;
    logic            res_vld, err_lk, err_to;
    logic [RL-1:0]   lm_num_q, lk_q;

    int              tests = 0;
    int              fails = 0;
    logic [W-1:0]    exp_res = '0;
    bit              acc;

    ekf_stage_seq #(.DW(DW), .NSTG(NSTG), .NRES(NRES), .ROW_LEN(RL), .TO_CYC(8)) dut (
        .clk(clk), .sys_rst(sys_rst), .stage_val(stage_val), .stage_rdy(stage_rdy),
        .landmark_num(landmark_num), .l_k(l_k), .init(init), .done(done),
        .result(result), .res_q(res_q), .res_vld(res_vld), .lm_num_q(lm_num_q),
        .lk_q(lk_q), .cur_stage(cur_stage), .err_lk(err_lk), .err_to(err_to)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] lowest(input logic [2:0] v);
        logic [2:0] r = '0;
        for (int i = 0; i < 3; i++) begin
            if (v[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bus();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Issue one request; leaves the DUT in its first WAIT cycle when accepted.
    task automatic request(input logic [2:0] sv, input logic [RL-1:0] lm, input logic [RL-1:0] lk,
                           input bit launch_done, output bit accepted);
        logic [2:0] sel;
        sel = lowest(sv);
        accepted = !(sel == 3'b100 && lk >= lm);
        stage_val = sv; landmark_num = lm; l_k = lk;
        cyc();
        stage_val = '0;
        chk("lm_num_q", lm_num_q, lm);
        chk("lk_q", lk_q, lk);
        if (accepted) begin
            chk("init_sel", init, sel);
            chk("cur_stage", cur_stage, sel);
            chk("rdy_busy", stage_rdy, 3'b000);
            chk("err_lk_clear", err_lk, 0);
        end else begin
            chk("err_lk", err_lk, 1);
            chk("init_none", init, 0);
            chk("rdy_idle", stage_rdy, 3'b111);
        end
        if (launch_done) begin
            done = sel;
            result = rand_bus();
        end
        cyc();
        done = '0;
        chk("init_off", init, 0);
        chk("err_lk_off", err_lk, 0);
        chk("no_vld_early", res_vld, 0);
        chk("res_q_hold_req", res_q, exp_res);
        if (accepted) chk("cur_hold", cur_stage, sel);
    endtask

    task automatic complete(input logic [2:0] sel, input int nwait, input bit noise,
                            input logic [W-1:0] val, input bit chain);
        repeat (nwait) begin
            if (noise) begin
                stage_val = 3'($urandom_range(1, 7));
                done = ~sel;
                result = rand_bus();
            end
            cyc();
            stage_val = '0; done = '0;
            chk("wait_novld", res_vld, 0);
            chk("wait_busy", stage_rdy, 3'b000);
            chk("wait_cur", cur_stage, sel);
            chk("wait_init", init, 0);
            chk("wait_res_q", res_q, exp_res);
        end
        result = val; done = sel;
        cyc();
        done = '0;
        exp_res = val;
        chk("res_vld", res_vld, 1);
        chk("res_q", res_q, exp_res);
        chk("rdy_after_done", stage_rdy, 3'b111);
        chk("cur_idle", cur_stage, 0);
        if (!chain) begin
            cyc();
            chk("res_vld_pulse", res_vld, 0);
            chk("res_q_hold", res_q, exp_res);
        end
    endtask

    initial begin
        logic [W-1:0] v;
        logic [2:0]   sv;
        logic [RL-1:0] lm, lk;

        cyc(); cyc();
        chk("rst_rdy", stage_rdy, 3'b000);
        chk("rst_res_q", res_q, 0);
        chk("rst_init", init, 0);
        chk("rst_cur", cur_stage, 0);
        chk("rst_vld", res_vld, 0);
        chk("rst_lm", lm_num_q, 0);
        chk("rst_lk", lk_q, 0);
        chk("rst_err_lk", err_lk, 0);
        chk("rst_err_to", err_to, 0);
        sys_rst = 1'b1;
        cyc();
        chk("rdy_after_release", stage_rdy, 3'b111);

        v = '0;
        v[1*DW +: DW] = 16'd1; v[2*DW +: DW] = 16'd2; v[3*DW +: DW] = 16'd3;
        request(3'b001, 10'd5, 10'd0, 1'b0, acc);
        complete(3'b001, 4, 1'b0, v, 1'b0);

        request(3'b110, 10'd3, 10'd9, 1'b0, acc);
        complete(3'b010, 2, 1'b0, rand_bus(), 1'b0);

        request(3'b100, 10'd6, 10'd6, 1'b0, acc);
        request(3'b100, 10'd6, 10'd4, 1'b0, acc);
        complete(3'b100, 1, 1'b0, rand_bus(), 1'b0);

        request(3'b001, 10'd2, 10'd1, 1'b0, acc);
        complete(3'b001, 3, 1'b1, rand_bus(), 1'b0);

        request(3'b010, 10'd7, 10'd7, 1'b1, acc);
        complete(3'b010, 2, 1'b0, rand_bus(), 1'b1);
        request(3'b100, 10'd9, 10'd2, 1'b0, acc);
        complete(3'b100, 0, 1'b0, rand_bus(), 1'b0);

        request(3'b001, 10'd4, 10'd1, 1'b0, acc);
        sys_rst = 1'b0;
        cyc();
        chk("midrst_rdy", stage_rdy, 3'b000);
        cyc();
        exp_res = '0;
        chk("midrst_res_q", res_q, 0);
        chk("midrst_cur", cur_stage, 0);
        chk("midrst_lk", lk_q, 0);
        sys_rst = 1'b1;
        cyc();
        chk("midrst_rdy_release", stage_rdy, 3'b111);
        done = 3'b001; result = rand_bus();
        cyc();
        done = '0;
        chk("stale_done_vld", res_vld, 0);
        chk("stale_done_res_q", res_q, 0);
        chk("stale_done_rdy", stage_rdy, 3'b111);

`ifdef STAGE_TIMEOUT_EN
        request(3'b001, 10'd4, 10'd1, 1'b0, acc);
        repeat (7) begin
            cyc();
            chk("to_quiet", err_to, 0);
        end
        cyc();
        chk("to_pulse", err_to, 1);
        chk("to_res_q", res_q, exp_res);
        chk("to_rdy", stage_rdy, 3'b111);
        cyc();
        chk("to_pulse_end", err_to, 0);
`else
        chk("err_to_const", err_to, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            sv = 3'($urandom_range(1, 7));
            lm = RL'($urandom_range(0, 15));
            lk = RL'($urandom_range(0, 15));
            request(sv, lm, lk, 1'($urandom_range(0, 1)), acc);
            if (acc) complete(lowest(sv), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                              rand_bus(), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
